// File: rtl/pixel_tx_pkg.sv
// Shared types, sizes and the byte-select helper for the pixel transmit serializer.
package pixel_tx_pkg;

    localparam int BYTE_W      = 8;
    localparam int PIXEL_BYTES = 3;
    localparam int PIXEL_W     = BYTE_W * PIXEL_BYTES;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } ptx_state_t;

    // Byte 0 is R (MSBs), byte 1 is G, byte 2 is B; the unreachable index 3 falls back to R.
    function automatic logic [BYTE_W-1:0] select_byte(input logic [PIXEL_W-1:0] px,
                                                      input logic [1:0]         idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = px[23:16];
            2'd1:    b = px[15:8];
            2'd2:    b = px[7:0];
            default: b = px[23:16];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pixel_tx_gap_timer.sv
// Down-counter timing the idle gap between bytes; zero is high once the gap has elapsed.
module pixel_tx_gap_timer #(
    parameter int GAP_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic zero
);

    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [CNT_W-1:0] cnt_r;

    // Load the gap length on request, then count down and park at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/pixel_tx_serializer.sv
// Serializes one 24-bit RGB pixel into three UART bytes (R, G, B) with an optional idle gap.
module pixel_tx_serializer
    import pixel_tx_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIXEL_W-1:0] pixel,
    input  logic               pixel_valid,
    output logic               pixel_ready,
    input  logic               tx_ready,
    input  logic               tx_done,
    output logic               tx_start,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               pixel_done
);

    localparam logic [1:0] LAST_IDX = 2'(PIXEL_BYTES - 1);

    ptx_state_t         state_r, state_s;
    logic [1:0]         byte_idx_r, byte_idx_s;
    logic [PIXEL_W-1:0] shadow_r, shadow_s;
    logic [BYTE_W-1:0]  tx_data_r, tx_data_s;
    logic               tx_start_r, tx_start_s;
    logic               pixel_done_r, pixel_done_s;
    logic               gap_load_s;
    logic               gap_zero_s;

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            pixel_tx_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
                .clk   (clk),
                .reset (reset),
                .load  (gap_load_s),
                .zero  (gap_zero_s)
            );
        end else begin : g_no_gap
            logic gap_unused_s;
            assign gap_unused_s = gap_load_s;
            assign gap_zero_s   = 1'b1;
        end
    endgenerate

    // State, byte pointer, captured pixel and registered UART/pixel outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            byte_idx_r   <= 2'd0;
            shadow_r     <= {PIXEL_W{1'b0}};
            tx_data_r    <= {BYTE_W{1'b0}};
            tx_start_r   <= 1'b0;
            pixel_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            byte_idx_r   <= byte_idx_s;
            shadow_r     <= shadow_s;
            tx_data_r    <= tx_data_s;
            tx_start_r   <= tx_start_s;
            pixel_done_r <= pixel_done_s;
        end
    end

    // Next-state and next-output decode; pulses default low, everything else holds.
    always_comb begin
        state_s      = state_r;
        byte_idx_s   = byte_idx_r;
        shadow_s     = shadow_r;
        tx_data_s    = tx_data_r;
        tx_start_s   = 1'b0;
        pixel_done_s = 1'b0;
        gap_load_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (pixel_valid) begin
                    shadow_s   = pixel;
                    byte_idx_s = 2'd0;
                    state_s    = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_data_s  = select_byte(shadow_r, byte_idx_r);
                    tx_start_s = 1'b1;
                    state_s    = WAIT_DONE;
                end else begin
                    state_s = SEND;
                end
            end
            WAIT_DONE: begin
                // A done seen while our own start is still high belongs to an earlier byte.
                if (tx_done && !tx_start_r) begin
                    if (byte_idx_r == LAST_IDX) begin
                        pixel_done_s = 1'b1;
                        state_s      = IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        byte_idx_s = byte_idx_r + 2'd1;
                        state_s    = SEND;
                    end else begin
                        gap_load_s = 1'b1;
                        state_s    = GAP;
                    end
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            GAP: begin
                if (gap_zero_s) begin
                    byte_idx_s = byte_idx_r + 2'd1;
                    state_s    = SEND;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign pixel_ready = (state_r == IDLE);
    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign pixel_done  = pixel_done_r;

endmodule

// File: tb/tb_pixel_tx_serializer.sv
// Directed bench for pixel_tx_serializer: instance a (no gap) and instance b (4-cycle gap).
module tb_pixel_tx_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pixel_a, pixel_b;
    logic        pv_a, pv_b, pr_a, pr_b, txr_a, txr_b;
    logic        done_m_a = 1'b0, done_m_b = 1'b0, done_x_a;
    logic        txd_a, txd_b, ts_a, ts_b, pd_a, pd_b;
    logic [7:0]  tdat_a, tdat_b;

    int cyc = 0;
    int dly = 10;
    int cnt_a = 0, cnt_b = 0;
    int n_chk = 0, n_fail = 0;

    int         st_cyc_a[$], st_cyc_b[$], pd_cyc_a[$], pd_cyc_b[$];
    int         dn_cyc_a[$], dn_cyc_b[$], acc_cyc_a[$], acc_cyc_b[$];
    logic [7:0] st_dat_a[$], st_dat_b[$], exp_a[$], exp_b[$];

    assign txd_a = done_m_a | done_x_a;
    assign txd_b = done_m_b;

    pixel_tx_serializer #(.GAP_CYCLES(0)) dut_a (
        .clk(clk), .reset(rst_n), .pixel(pixel_a), .pixel_valid(pv_a), .pixel_ready(pr_a),
        .tx_ready(txr_a), .tx_done(txd_a), .tx_start(ts_a), .tx_data(tdat_a), .pixel_done(pd_a)
    );

    pixel_tx_serializer #(.GAP_CYCLES(4)) dut_b (
        .clk(clk), .reset(rst_n), .pixel(pixel_b), .pixel_valid(pv_b), .pixel_ready(pr_b),
        .tx_ready(txr_b), .tx_done(txd_b), .tx_start(ts_b), .tx_data(tdat_b), .pixel_done(pd_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART models: tx_done pulses dly cycles after each tx_start.
    always @(posedge clk) begin
        if (!rst_n) begin
            cnt_a <= 0; done_m_a <= 1'b0;
        end else begin
            done_m_a <= 1'b0;
            if (ts_a) cnt_a <= dly;
            else if (cnt_a != 0) begin
                cnt_a <= cnt_a - 1;
                if (cnt_a == 1) done_m_a <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            cnt_b <= 0; done_m_b <= 1'b0;
        end else begin
            done_m_b <= 1'b0;
            if (ts_b) cnt_b <= dly;
            else if (cnt_b != 0) begin
                cnt_b <= cnt_b - 1;
                if (cnt_b == 1) done_m_b <= 1'b1;
            end
        end
    end

    // Accept monitor: records the cycle in which valid & ready were both high.
    always @(posedge clk) begin
        if (rst_n && pv_a && pr_a) acc_cyc_a.push_back(cyc);
        if (rst_n && pv_b && pr_b) acc_cyc_b.push_back(cyc);
    end

    // Output monitor: records start/done/pixel_done cycles and transmitted bytes.
    always @(negedge clk) begin
        if (ts_a) begin st_cyc_a.push_back(cyc); st_dat_a.push_back(tdat_a); end
        if (ts_b) begin st_cyc_b.push_back(cyc); st_dat_b.push_back(tdat_b); end
        if (pd_a) pd_cyc_a.push_back(cyc);
        if (pd_b) pd_cyc_b.push_back(cyc);
        if (done_m_a) dn_cyc_a.push_back(cyc);
        if (done_m_b) dn_cyc_b.push_back(cyc);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [23:0] px);
        pixel_a = px; pv_a = 1'b1;
        exp_a.push_back(px[23:16]); exp_a.push_back(px[15:8]); exp_a.push_back(px[7:0]);
        step();
        pv_a = 1'b0;
    endtask

    task automatic wait_pd(input bit inst_b, input int total);
        int t = 0;
        while (((inst_b ? pd_cyc_b.size() : pd_cyc_a.size()) < total) && t < 400) begin
            step(); t++;
        end
        chk("pixel_done_wait", inst_b ? pd_cyc_b.size() : pd_cyc_a.size(), total);
    endtask

    task automatic wait_st(input bit inst_b, input int total);
        int t = 0;
        while (((inst_b ? st_cyc_b.size() : st_cyc_a.size()) < total) && t < 400) begin
            step(); t++;
        end
        chk("tx_start_wait", inst_b ? st_cyc_b.size() : st_cyc_a.size(), total);
    endtask

    task automatic chk_bytes(input bit inst_b, input int s0, input int n);
        for (int i = 0; i < n; i++) begin
            if (inst_b) chk("byte_b", st_dat_b[s0 + i], exp_b.pop_front());
            else        chk("byte_a", st_dat_a[s0 + i], exp_a.pop_front());
        end
    endtask

    initial begin
        int s0, p0, a0, d0, c, t;
        rst_n = 1'b0; pixel_a = 24'h0; pixel_b = 24'h0;
        pv_a = 1'b1; pv_b = 1'b1; txr_a = 1'b1; txr_b = 1'b1; done_x_a = 1'b0;
        repeat (3) step();
        // Reset state, with pixel_valid offered during reset
        chk("rst_ready_a", pr_a, 1); chk("rst_start_a", ts_a, 0);
        chk("rst_data_a", tdat_a, 8'h00); chk("rst_pdone_a", pd_a, 0);
        chk("rst_ready_b", pr_b, 1); chk("rst_start_b", ts_b, 0);
        chk("rst_data_b", tdat_b, 8'h00); chk("rst_pdone_b", pd_b, 0);
        pv_a = 1'b0; pv_b = 1'b0;
        step(); rst_n = 1'b1; repeat (2) step();
        chk("rst_no_start_a", st_cyc_a.size(), 0);

        // Basic pixel, no gap
        s0 = st_cyc_a.size(); p0 = pd_cyc_a.size(); a0 = acc_cyc_a.size(); d0 = dn_cyc_a.size();
        send_a(24'hA1B2C3);
        wait_pd(1'b0, p0 + 1);
        repeat (3) step();
        chk_bytes(1'b0, s0, 3);
        chk("basic_start_count", st_cyc_a.size(), s0 + 3);
        chk("basic_pdone_count", pd_cyc_a.size(), p0 + 1);
        chk("basic_latency", st_cyc_a[s0], acc_cyc_a[a0] + 2);
        chk("basic_rate_g", st_cyc_a[s0 + 1], dn_cyc_a[d0] + 2);
        chk("basic_rate_b", st_cyc_a[s0 + 2], dn_cyc_a[d0 + 1] + 2);
        chk("basic_pdone_time", pd_cyc_a[p0], dn_cyc_a[d0 + 2] + 1);

        // Backpressure: tx_ready low while in SEND
        s0 = st_cyc_a.size(); p0 = pd_cyc_a.size();
        txr_a = 1'b0;
        send_a(24'h112233);
        repeat (20) step();
        chk("bp_no_start", st_cyc_a.size(), s0);
        chk("bp_data_held", tdat_a, 8'hC3);
        chk("bp_not_ready", pr_a, 0);
        txr_a = 1'b1; c = cyc;
        step();
        chk("bp_start_pulse", ts_a, 1);
        chk("bp_start_time", st_cyc_a[s0], c + 1);
        wait_pd(1'b0, p0 + 1);
        repeat (3) step();
        chk_bytes(1'b0, s0, 3);
        chk("bp_start_count", st_cyc_a.size(), s0 + 3);

        // Spurious tx_done in IDLE and in the tx_start cycle; pixel changes after accept
        s0 = st_cyc_a.size(); p0 = pd_cyc_a.size(); d0 = dn_cyc_a.size();
        done_x_a = 1'b1; step(); done_x_a = 1'b0;
        repeat (3) step();
        chk("idle_done_no_start", st_cyc_a.size(), s0);
        chk("idle_done_no_pdone", pd_cyc_a.size(), p0);
        chk("idle_done_ready", pr_a, 1);
        send_a(24'h5A6B7C);
        pixel_a = 24'hFFFFFF;
        t = 0;
        while (!ts_a && t < 50) begin step(); t++; end
        chk("spur_seen_start", ts_a, 1);
        done_x_a = 1'b1; step(); done_x_a = 1'b0;
        wait_pd(1'b0, p0 + 1);
        repeat (3) step();
        chk_bytes(1'b0, s0, 3);
        chk("spur_rate_g", st_cyc_a[s0 + 1], dn_cyc_a[d0] + 2);
        chk("spur_start_count", st_cyc_a.size(), s0 + 3);

        // Back-to-back pixels with pixel_valid held
        s0 = st_cyc_a.size(); p0 = pd_cyc_a.size(); a0 = acc_cyc_a.size();
        pixel_a = 24'h010203; pv_a = 1'b1;
        exp_a.push_back(8'h01); exp_a.push_back(8'h02); exp_a.push_back(8'h03);
        step();
        pixel_a = 24'h040506;
        exp_a.push_back(8'h04); exp_a.push_back(8'h05); exp_a.push_back(8'h06);
        t = 0;
        while (acc_cyc_a.size() < a0 + 2 && t < 300) begin step(); t++; end
        pv_a = 1'b0;
        chk("b2b_accepts", acc_cyc_a.size(), a0 + 2);
        wait_pd(1'b0, p0 + 2);
        repeat (3) step();
        chk("b2b_accept_in_pdone", acc_cyc_a[a0 + 1], pd_cyc_a[p0]);
        chk_bytes(1'b0, s0, 6);
        chk("b2b_start_count", st_cyc_a.size(), s0 + 6);

        // Reset during the G byte; next pixel restarts from R
        s0 = st_cyc_a.size(); p0 = pd_cyc_a.size();
        pixel_a = 24'hDEADBE; pv_a = 1'b1;
        exp_a.push_back(8'hDE); exp_a.push_back(8'hAD);
        step();
        pv_a = 1'b0;
        wait_st(1'b0, s0 + 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_start_low", ts_a, 0);
        chk("midrst_ready", pr_a, 1);
        chk("midrst_pdone_low", pd_a, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (15) step();
        chk("midrst_no_pdone", pd_cyc_a.size(), p0);
        chk("midrst_start_count", st_cyc_a.size(), s0 + 2);
        a0 = acc_cyc_a.size();
        send_a(24'h778899);
        wait_pd(1'b0, p0 + 1);
        chk_bytes(1'b0, s0, 5);
        chk("midrst_restart_lat", st_cyc_a[s0 + 2], acc_cyc_a[a0] + 2);

        // Gap instance: 4 idle cycles between bytes, none after B
        s0 = st_cyc_b.size(); p0 = pd_cyc_b.size(); a0 = acc_cyc_b.size(); d0 = dn_cyc_b.size();
        pixel_b = 24'hC0FFEE; pv_b = 1'b1;
        exp_b.push_back(8'hC0); exp_b.push_back(8'hFF); exp_b.push_back(8'hEE);
        step();
        pv_b = 1'b0;
        wait_pd(1'b1, p0 + 1);
        repeat (3) step();
        chk_bytes(1'b1, s0, 3);
        chk("gap_latency", st_cyc_b[s0], acc_cyc_b[a0] + 2);
        chk("gap_rate_g", st_cyc_b[s0 + 1], dn_cyc_b[d0] + 6);
        chk("gap_rate_b", st_cyc_b[s0 + 2], dn_cyc_b[d0 + 1] + 6);
        chk("gap_pdone_time", pd_cyc_b[p0], dn_cyc_b[d0 + 2] + 1);
        chk("gap_start_count", st_cyc_b.size(), s0 + 3);
        chk("gap_pdone_count", pd_cyc_b.size(), p0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
